kronos_hazard_tracker: RTL

//  Parametrised register hazard tracker for the Kronos decode stage. It counts in-flight writes
//  per architectural register, up to DEPTH writes per register. It stalls decode on read-after-write

---
 rtl/kronos_types.sv | 12 +
 rtl/kronos_hcu_cell.sv | 43 ++++
 rtl/kronos_hazard_tracker.sv | 124 ++++++++++++
 3 files changed

// File: rtl/kronos_types.sv
// Shared types and defaults for the Kronos hazard tracker (hazard control unit).
package kronos_types;

    localparam int HCU_DEPTH_DEFAULT = 2;
    localparam int HCU_NREGS_DEFAULT = 32;

    // Width of a per-register pending-write counter that must hold 0..depth.
    function automatic int hcu_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/kronos_hcu_cell.sv
// One saturating up/down counter of pending writes for a single architectural register.
// inc and dec in the same cycle cancel; clr has priority over both.
module kronos_hcu_cell
    import kronos_types::*;
#(
    parameter int DEPTH = HCU_DEPTH_DEFAULT,
    localparam int CW   = hcu_cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          nz,
    output logic          full,
    output logic          one
);

    localparam logic [CW-1:0] MAX = CW'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] r_cnt;

    // Pending-write count: clear on flush, otherwise saturate at 0 and DEPTH.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !dec) begin
            if (r_cnt != MAX) r_cnt <= r_cnt + ONE;
        end else if (dec && !inc) begin
            if (r_cnt != '0) r_cnt <= r_cnt - ONE;
        end
    end

    assign cnt  = r_cnt;
    assign nz   = (r_cnt != '0);
    assign full = (r_cnt == MAX);
    assign one  = (r_cnt == ONE);

endmodule

// File: rtl/kronos_hazard_tracker.sv
// Register hazard tracker for the Kronos decode stage.
// Counts in-flight writes per architectural register (x0 untracked) and stalls decode on
// read-after-write hazards or when the destination counter is saturated.
// Optional feature: define KRONOS_HCU_FORWARD_EN to forward write-back data into decode when
// the last pending write of a source register retires in the same cycle.
//
// Handshake: upgrade is a one-cycle strobe from decode meaning "an instruction writing rd has
// been handed off" (only meaningful with regwr_rd_en, never asserted while stall is high);
// downgrade is a one-cycle strobe from write-back meaning "regwr_sel is written this cycle".
// Neither side waits on the other; both are consumed at the posedge where they are high.
module kronos_hazard_tracker
    import kronos_types::*;
#(
    parameter int NREGS = HCU_NREGS_DEFAULT,
    parameter int DEPTH = HCU_DEPTH_DEFAULT,
    localparam int REGW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rstz,
    input  logic            flush,
    input  logic [REGW-1:0] rs1,
    input  logic [REGW-1:0] rs2,
    input  logic [REGW-1:0] rd,
    input  logic            regrd_rs1_en,
    input  logic            regrd_rs2_en,
    input  logic            regwr_rd_en,
    input  logic            upgrade,
    input  logic [REGW-1:0] regwr_sel,
    input  logic [31:0]     regwr_data,
    input  logic            downgrade,
    output logic            stall,
    output logic            fwd_rs1_en,
    output logic            fwd_rs2_en,
    output logic [31:0]     fwd_data,
    output logic            idle,
    output logic            underflow
);

    localparam int CW = hcu_cnt_width(DEPTH);

    logic [NREGS-1:0]         w_inc;
    logic [NREGS-1:0]         w_dec;
    logic [NREGS-1:0][CW-1:0] w_cnt;
    logic [NREGS-1:0]         w_nz;
    logic [NREGS-1:0]         w_full;
    logic [NREGS-1:0]         w_one;

    logic w_haz_rs1;
    logic w_haz_rs2;
    logic w_full_rd;
    logic w_fwd_rs1;
    logic w_fwd_rs2;
    logic w_unused;

    logic r_underflow;

    // One-hot decode of the decode-side and write-back-side register selects; x0 is dropped.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (upgrade && (rd != '0))          w_inc[rd]        = 1'b1;
        if (downgrade && (regwr_sel != '0)) w_dec[regwr_sel] = 1'b1;
    end

    // x0 has no cell; it always reads as an empty counter.
    assign w_cnt[0]  = '0;
    assign w_nz[0]   = 1'b0;
    assign w_full[0] = 1'b0;
    assign w_one[0]  = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_cell
        kronos_hcu_cell #(
            .DEPTH (DEPTH)
        ) u_cell (
            .clk  (clk),
            .rstz (rstz),
            .clr  (flush),
            .inc  (w_inc[g]),
            .dec  (w_dec[g]),
            .cnt  (w_cnt[g]),
            .nz   (w_nz[g]),
            .full (w_full[g]),
            .one  (w_one[g])
        );
    end

    assign w_haz_rs1 = regrd_rs1_en && (rs1 != '0) && w_nz[rs1];
    assign w_haz_rs2 = regrd_rs2_en && (rs2 != '0) && w_nz[rs2];
    assign w_full_rd = regwr_rd_en  && (rd  != '0) && w_full[rd];

`ifdef KRONOS_HCU_FORWARD_EN
    // A source whose only pending write retires this cycle can take the write-back data.
    assign w_fwd_rs1 = w_haz_rs1 && w_one[rs1] && downgrade && (regwr_sel == rs1);
    assign w_fwd_rs2 = w_haz_rs2 && w_one[rs2] && downgrade && (regwr_sel == rs2);
    assign fwd_data  = regwr_data;
    assign w_unused  = ^{w_cnt, w_inc[0], w_dec[0]};
`else
    assign w_fwd_rs1 = 1'b0;
    assign w_fwd_rs2 = 1'b0;
    assign fwd_data  = '0;
    assign w_unused  = ^{w_cnt, w_one, regwr_data, w_inc[0], w_dec[0]};
`endif

    assign fwd_rs1_en = w_fwd_rs1;
    assign fwd_rs2_en = w_fwd_rs2;
    assign stall      = (w_haz_rs1 && !w_fwd_rs1) || (w_haz_rs2 && !w_fwd_rs2) || w_full_rd;
    assign idle       = ~|w_nz;

    // Flag a write-back to a register with nothing pending; a flush in the same cycle masks it.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= !flush && downgrade && (regwr_sel != '0) && !w_nz[regwr_sel];
        end
    end

    assign underflow = r_underflow;

    // Decode must never hand off a write to a register whose counter is already saturated.
    a_no_sat_upgrade: assert property (@(posedge clk) disable iff (!rstz)
        !(upgrade && !flush && (rd != '0) && w_full[rd]));

endmodule
